dice_roll_ctrl: RTL and testbench

Sequencing controller for the dice datapath. It takes debounced die-select buttons and the 32 Hz prescaler tick, and runs the roll sequence: spin while a button is held, then coast with slowing steps after release, then settle. It owns the BCD result register (digit10/digit1) that feeds the seven-segment output stage. It also drives the blanking and status flags that the digit multiplexer uses.

---
 rtl/dice_pkg.sv | 61 ++++++
 rtl/bcd_die_dec.sv | 32 +++
 rtl/dice_roll_ctrl.sv | 156 +++++++++++++++
 tb/tb_dice_roll_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared definitions for the dice roll controller: die indices, state
// encoding, BCD value type and the per-die top-value / button-priority helpers.
package dice_pkg;

    localparam int NUM_DICE = 7;

    localparam logic [2:0] DIE_D4   = 3'd0;
    localparam logic [2:0] DIE_D6   = 3'd1;
    localparam logic [2:0] DIE_D8   = 3'd2;
    localparam logic [2:0] DIE_D10  = 3'd3;
    localparam logic [2:0] DIE_D12  = 3'd4;
    localparam logic [2:0] DIE_D20  = 3'd5;
    localparam logic [2:0] DIE_D100 = 3'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPIN  = 2'd1,
        COAST = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_t;

    // Top face of each die in BCD; the D100 top face 100 is shown as "00".
    function automatic bcd_t die_top(input logic [2:0] die);
        bcd_t top;
        top.tens  = 4'd0;
        top.units = 4'd0;
        case (die)
            DIE_D4:  top.units = 4'd4;
            DIE_D6:  top.units = 4'd6;
            DIE_D8:  top.units = 4'd8;
            DIE_D10: top.tens  = 4'd1;
            DIE_D12: begin
                top.tens  = 4'd1;
                top.units = 4'd2;
            end
            DIE_D20: top.tens  = 4'd2;
            default: begin
                top.tens  = 4'd0;
                top.units = 4'd0;
            end
        endcase
        return top;
    endfunction

    // Lowest set button wins; scanning downward lets the lowest index overwrite.
    function automatic logic [2:0] btn_priority(input logic [NUM_DICE-1:0] btn);
        logic [2:0] idx;
        idx = DIE_D6;
        for (int i = NUM_DICE - 1; i >= 0; i--) begin
            if (btn[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bcd_die_dec.sv
// Combinational BCD decrement of the displayed die value. The value 01 wraps
// to the top face of the latched die, so D100 steps 01 -> 00 (=100) -> 99.
module bcd_die_dec
    import dice_pkg::*;
(
    input  logic [3:0] tens,
    input  logic [3:0] units,
    input  logic [2:0] die,
    output logic [3:0] next_tens,
    output logic [3:0] next_units
);

    bcd_t top;

    assign top = die_top(die);

    // One BCD step down with borrow, tens digit wrapping 0 -> 9.
    always_comb begin
        next_tens  = tens;
        next_units = units;
        if (tens == 4'd0 && units == 4'd1) begin
            next_tens  = top.tens;
            next_units = top.units;
        end else if (units != 4'd0) begin
            next_units = units - 4'd1;
        end else begin
            next_units = 4'd9;
            next_tens  = (tens == 4'd0) ? 4'd9 : tens - 4'd1;
        end
    end

endmodule

// File: rtl/dice_roll_ctrl.sv
// Roll sequencer: spins the value at clock rate while a die button is held,
// coasts with lengthening tick intervals after release, then settles in IDLE.
// Owns the BCD result register and the blanking/rolling flags.
module dice_roll_ctrl
    import dice_pkg::*;
#(
    parameter int COAST_STEPS = 8,
    parameter int WAIT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_i,
    input  logic [6:0] btn_i,
    output logic [3:0] digit1_o,
    output logic [3:0] digit10_o,
    output logic       show_o,
    output logic       rolling_o,
    output logic [2:0] die_o
);

    localparam logic [WAIT_W-1:0] ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(COAST_STEPS);

    state_t            state_reg, state_next;
    logic [2:0]        die_reg, die_next;
    logic [3:0]        tens_reg, tens_next;
    logic [3:0]        units_reg, units_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [WAIT_W-1:0] step_reg, step_next;
    logic              show_reg, show_next;
    logic              rolling_reg, rolling_next;

    logic       any_btn;
    logic [2:0] btn_die;
    bcd_t       btn_top;
    logic [3:0] dec_tens;
    logic [3:0] dec_units;
    logic       coast_fire;
    logic       last_step;

    assign any_btn    = |btn_i;
    assign btn_die    = btn_priority(btn_i);
    assign btn_top    = die_top(btn_die);
    // Step k completes on its k-th tick: the tick that would bring wait up to step.
    assign coast_fire = tick_i && ((wait_reg + ONE) == step_reg);
    assign last_step  = (step_reg == LAST);

    bcd_die_dec u_dec (
        .tens       (tens_reg),
        .units      (units_reg),
        .die        (die_reg),
        .next_tens  (dec_tens),
        .next_units (dec_units)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decision; a button in COAST abandons the coast and restarts a spin.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (any_btn) state_next = SPIN;
            end
            SPIN: begin
                if (!any_btn) state_next = COAST;
            end
            COAST: begin
                if (any_btn) begin
                    state_next = SPIN;
                end else if (coast_fire && last_step) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output flags decoded from the upcoming state so they land registered with it.
    always_comb begin
        show_next    = (state_next != SPIN);
        rolling_next = (state_next != IDLE);
    end

    // Datapath next values: die latch, BCD value and coast wait/step counters.
    always_comb begin
        die_next   = die_reg;
        tens_next  = tens_reg;
        units_next = units_reg;
        wait_next  = wait_reg;
        step_next  = step_reg;
        unique case (state_reg)
            IDLE, COAST: begin
                if (any_btn) begin
                    die_next   = btn_die;
                    tens_next  = btn_top.tens;
                    units_next = btn_top.units;
                end else if (state_reg == COAST && tick_i) begin
                    if (coast_fire) begin
                        tens_next  = dec_tens;
                        units_next = dec_units;
                        wait_next  = '0;
                        step_next  = step_reg + ONE;
                    end else begin
                        wait_next  = wait_reg + ONE;
                    end
                end
            end
            SPIN: begin
                if (any_btn) begin
                    tens_next  = dec_tens;
                    units_next = dec_units;
                end else begin
                    wait_next  = '0;
                    step_next  = ONE;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            die_reg     <= DIE_D6;
            tens_reg    <= 4'd0;
            units_reg   <= 4'd1;
            wait_reg    <= '0;
            step_reg    <= '0;
            show_reg    <= 1'b1;
            rolling_reg <= 1'b0;
        end else begin
            die_reg     <= die_next;
            tens_reg    <= tens_next;
            units_reg   <= units_next;
            wait_reg    <= wait_next;
            step_reg    <= step_next;
            show_reg    <= show_next;
            rolling_reg <= rolling_next;
        end
    end

    assign digit1_o  = units_reg;
    assign digit10_o = tens_reg;
    assign show_o    = show_reg;
    assign rolling_o = rolling_reg;
    assign die_o     = die_reg;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Self-checking bench for dice_roll_ctrl. The reference model treats the die
// value as a plain integer 1..N (D100 top face = 100) and derives coast
// decrement points from triangular tick counts.
module tb_dice_roll_ctrl;

    localparam int COAST_STEPS = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick_i = 1'b0;
    logic [6:0] btn_i  = 7'd0;
    logic [3:0] digit1_o;
    logic [3:0] digit10_o;
    logic       show_o;
    logic       rolling_o;
    logic [2:0] die_o;

    int errors = 0;
    int checks = 0;

    dice_roll_ctrl #(
        .COAST_STEPS (COAST_STEPS),
        .WAIT_W      (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_i    (tick_i),
        .btn_i     (btn_i),
        .digit1_o  (digit1_o),
        .digit10_o (digit10_o),
        .show_o    (show_o),
        .rolling_o (rolling_o),
        .die_o     (die_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int top_of(input int idx);
        case (idx)
            0: return 4;
            1: return 6;
            2: return 8;
            3: return 10;
            4: return 12;
            5: return 20;
            default: return 100;
        endcase
    endfunction

    function automatic int first_set(input logic [6:0] b);
        for (int i = 0; i < 7; i++) begin
            if (b[i]) return i;
        end
        return -1;
    endfunction

    function automatic int dec_val(input int v, input int n);
        return (v == 1) ? n : v - 1;
    endfunction

    // Decrements completed after t coast ticks: largest k with k(k+1)/2 <= t.
    function automatic int steps_done(input int t);
        int k;
        k = 0;
        while (k < COAST_STEPS && ((k + 1) * (k + 2)) / 2 <= t) k++;
        return k;
    endfunction

    // Expected {tens, units, show, rolling, die}.
    function automatic logic [12:0] expv(input int v, input int die, input bit show, input bit roll);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'((v % 100) / 10);
        u = 4'(v % 10);
        return {t, u, show, roll, 3'(die)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Press from IDLE/COAST, hold for the load cycle plus `spins` SPIN cycles, release.
    task automatic press_and_spin(input logic [6:0] b, input int spins, input logic [6:0] b_during,
                                  output int die, output int val);
        logic [12:0] e;
        die = first_set(b);
        val = top_of(die);
        btn_i = b;
        cyc();
        e = expv(val, die, 1'b0, 1'b1);
        checks++;
        if ({digit10_o, digit1_o, show_o, rolling_o, die_o} !== e) begin
            errors++;
            $display("FAIL load: got %0d%0d show=%0b roll=%0b die=%0d, expected %0d%0d show=%0b roll=%0b die=%0d",
                     digit10_o, digit1_o, show_o, rolling_o, die_o, e[12:9], e[8:5], e[4], e[3], e[2:0]);
        end
        for (int i = 0; i < spins; i++) begin
            btn_i  = b_during;
            tick_i = 1'($urandom_range(0, 1));
            cyc();
            tick_i = 1'b0;
            val = dec_val(val, top_of(die));
            e = expv(val, die, 1'b0, 1'b1);
            checks++;
            if ({digit10_o, digit1_o, show_o, rolling_o, die_o} !== e) begin
                errors++;
                $display("FAIL spin%0d: got %0d%0d show=%0b roll=%0b die=%0d, expected %0d%0d show=%0b roll=%0b die=%0d",
                         i, digit10_o, digit1_o, show_o, rolling_o, die_o, e[12:9], e[8:5], e[4], e[3], e[2:0]);
            end
        end
        btn_i = 7'd0;
        cyc();
        e = expv(val, die, 1'b1, 1'b1);
        checks++;
        if ({digit10_o, digit1_o, show_o, rolling_o, die_o} !== e) begin
            errors++;
            $display("FAIL release: got %0d%0d show=%0b roll=%0b die=%0d, expected %0d%0d show=%0b roll=%0b die=%0d",
                     digit10_o, digit1_o, show_o, rolling_o, die_o, e[12:9], e[8:5], e[4], e[3], e[2:0]);
        end
    endtask

    // Issue n_ticks single-cycle ticks with idle gaps, checking the value after every gap and tick.
    task automatic coast(input int die, input int start, input int n_ticks, output int val);
        logic [12:0] e;
        int prev_k;
        int k;
        val = start;
        prev_k = 0;
        for (int t = 1; t <= n_ticks; t++) begin
            repeat ($urandom_range(1, 3)) cyc();
            e = expv(val, die, 1'b1, prev_k < COAST_STEPS);
            checks++;
            if ({digit10_o, digit1_o, show_o, rolling_o, die_o} !== e) begin
                errors++;
                $display("FAIL gap%0d: got %0d%0d show=%0b roll=%0b die=%0d, expected %0d%0d show=%0b roll=%0b die=%0d",
                         t, digit10_o, digit1_o, show_o, rolling_o, die_o, e[12:9], e[8:5], e[4], e[3], e[2:0]);
            end
            tick_i = 1'b1;
            cyc();
            tick_i = 1'b0;
            k = steps_done(t);
            while (prev_k < k) begin
                val = dec_val(val, top_of(die));
                prev_k++;
            end
            e = expv(val, die, 1'b1, k < COAST_STEPS);
            checks++;
            if ({digit10_o, digit1_o, show_o, rolling_o, die_o} !== e) begin
                errors++;
                $display("FAIL tick%0d: got %0d%0d show=%0b roll=%0b die=%0d, expected %0d%0d show=%0b roll=%0b die=%0d",
                         t, digit10_o, digit1_o, show_o, rolling_o, die_o, e[12:9], e[8:5], e[4], e[3], e[2:0]);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [12:0] e;
        #2 rst_n = 1'b0;
        #10;
        e = expv(1, 1, 1'b1, 1'b0);
        checks++;
        if ({digit10_o, digit1_o, show_o, rolling_o, die_o} !== e) begin
            errors++;
            $display("FAIL reset: got %0d%0d show=%0b roll=%0b die=%0d, expected 01 show=1 roll=0 die=1",
                     digit10_o, digit1_o, show_o, rolling_o, die_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        $display("test_reset done");
    endtask

    task automatic test_d6();
        int die, val, fin;
        press_and_spin(7'b0000010, 3, 7'b0000010, die, val);
        coast(die, val, 36, fin);
        $display("test_d6: die=%0d spun=%0d final=%0d", die, val, fin);
    endtask

    task automatic test_d100_wrap();
        int die, val, fin;
        press_and_spin(7'b1000000, 2, 7'b1000000, die, val);
        coast(die, val, 36, fin);
        $display("test_d100_wrap: die=%0d spun=%0d final=%0d", die, val, fin);
    endtask

    task automatic test_priority();
        int die, val, fin;
        press_and_spin(7'b0101000, 4, 7'b0101001, die, val);
        coast(die, val, 36, fin);
        $display("test_priority: die=%0d spun=%0d final=%0d", die, val, fin);
    endtask

    task automatic test_reroll();
        logic [12:0] e;
        int die, val, mid, fin;
        press_and_spin(7'b0000100, 5, 7'b0000100, die, val);
        coast(die, val, 3, mid);
        btn_i = 7'b0000001;
        cyc();
        e = expv(4, 0, 1'b0, 1'b1);
        checks++;
        if ({digit10_o, digit1_o, show_o, rolling_o, die_o} !== e) begin
            errors++;
            $display("FAIL reroll: got %0d%0d show=%0b roll=%0b die=%0d, expected 04 show=0 roll=1 die=0",
                     digit10_o, digit1_o, show_o, rolling_o, die_o);
        end
        btn_i = 7'd0;
        cyc();
        e = expv(4, 0, 1'b1, 1'b1);
        checks++;
        if ({digit10_o, digit1_o, show_o, rolling_o, die_o} !== e) begin
            errors++;
            $display("FAIL reroll_release: got %0d%0d show=%0b roll=%0b die=%0d, expected 04 show=1 roll=1 die=0",
                     digit10_o, digit1_o, show_o, rolling_o, die_o);
        end
        coast(0, 4, 36, fin);
        $display("test_reroll: abandoned at %0d, final=%0d", mid, fin);
    endtask

    task automatic test_reset_mid_coast();
        logic [12:0] e;
        int die, val, mid;
        press_and_spin(7'b0010000, 7, 7'b0010000, die, val);
        coast(die, val, 5, mid);
        #2 rst_n = 1'b0;
        #1;
        e = expv(1, 1, 1'b1, 1'b0);
        checks++;
        if ({digit10_o, digit1_o, show_o, rolling_o, die_o} !== e) begin
            errors++;
            $display("FAIL async_reset: got %0d%0d show=%0b roll=%0b die=%0d, expected 01 show=1 roll=0 die=1",
                     digit10_o, digit1_o, show_o, rolling_o, die_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick_i = 1'b1;
        cyc();
        tick_i = 1'b0;
        checks++;
        if ({digit10_o, digit1_o, show_o, rolling_o, die_o} !== e) begin
            errors++;
            $display("FAIL post_reset_idle: got %0d%0d show=%0b roll=%0b die=%0d, expected 01 show=1 roll=0 die=1",
                     digit10_o, digit1_o, show_o, rolling_o, die_o);
        end
        $display("test_reset_mid_coast: reset at value %0d", mid);
    endtask

    task automatic test_random();
        int die, val, fin, spins, nt;
        logic [6:0] b;
        logic [6:0] bd;
        for (int r = 0; r < 6; r++) begin
            b     = 7'($urandom_range(1, 127));
            bd    = b | 7'($urandom);
            spins = $urandom_range(0, 20);
            nt    = 36 + $urandom_range(0, 4);
            press_and_spin(b, spins, bd, die, val);
            coast(die, val, nt, fin);
            $display("test_random %0d: btn=%b die=%0d spins=%0d ticks=%0d final=%0d", r, b, die, spins, nt, fin);
        end
    endtask

    initial begin
        test_reset();
        test_d6();
        test_d100_wrap();
        test_priority();
        test_reroll();
        test_reset_mid_coast();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
